// File: rtl/count_display_ctrl_pkg.sv
// ============================================================================
// Module      : count_display_ctrl_pkg
// Description : Segment codes, blanking/anode constants and digit indices
//               shared by the count display controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package count_display_ctrl_pkg;

    // Active-low gfedcba patterns
    localparam logic [6:0] c_SEG_0     = 7'b1000000;
    localparam logic [6:0] c_SEG_1     = 7'b1111001;
    localparam logic [6:0] c_SEG_2     = 7'b0100100;
    localparam logic [6:0] c_SEG_3     = 7'b0110000;
    localparam logic [6:0] c_SEG_4     = 7'b0011001;
    localparam logic [6:0] c_SEG_5     = 7'b0010010;
    localparam logic [6:0] c_SEG_6     = 7'b0000010;
    localparam logic [6:0] c_SEG_7     = 7'b1111000;
    localparam logic [6:0] c_SEG_8     = 7'b0000000;
    localparam logic [6:0] c_SEG_9     = 7'b0010000;
    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

    localparam logic [3:0] c_AN_OFF    = 4'b1111;

    localparam logic [1:0] c_DIG_0     = 2'd0;
    localparam logic [1:0] c_DIG_1     = 2'd1;
    localparam logic [1:0] c_DIG_2     = 2'd2;
    localparam logic [1:0] c_DIG_3     = 2'd3;

endpackage

`default_nettype wire

// File: rtl/count_display_ctrl_bcd_to_seg7.sv
// ============================================================================
// Module      : bcd_to_seg7
// Description : Combinational BCD digit to active-low seven-segment pattern,
//               with a blank override.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_seg7
    import count_display_ctrl_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = c_SEG_BLANK;
        if (!i_blank) begin
            case (i_digit)
                4'd0:    o_seg = c_SEG_0;
                4'd1:    o_seg = c_SEG_1;
                4'd2:    o_seg = c_SEG_2;
                4'd3:    o_seg = c_SEG_3;
                4'd4:    o_seg = c_SEG_4;
                4'd5:    o_seg = c_SEG_5;
                4'd6:    o_seg = c_SEG_6;
                4'd7:    o_seg = c_SEG_7;
                4'd8:    o_seg = c_SEG_8;
                4'd9:    o_seg = c_SEG_9;
                default: o_seg = c_SEG_BLANK;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/count_display_ctrl.sv
// ============================================================================
// Module      : count_display_ctrl
// Description : Samples the slow bit counter, counts 15->0 wraps in BCD and
//               scans both values onto a 4-digit common-anode display.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_display_ctrl
    import count_display_ctrl_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] counter_in,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       wrap_pulse
);

    localparam int               c_SCAN_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(REFRESH_DIV - 1);
    localparam logic [c_SCAN_W-1:0] c_SCAN_ONE  = c_SCAN_W'(1);

    logic [3:0]          r_sync [SYNC_STAGES];
    logic [3:0]          r_s_prev;
    logic [3:0]          r_value_q;
    logic [3:0]          r_wrap_ones;
    logic [3:0]          r_wrap_tens;
    logic                r_wrap_pulse;
    logic [c_SCAN_W-1:0] r_scan;
    logic [1:0]          r_idx;
    logic [3:0]          r_an;
    logic [6:0]          r_seg;
    logic                r_dp;

    logic [3:0]          w_s_sync;
    logic                w_accept;
    logic                w_wrap;
    logic                w_scan_tc;
    logic                w_val_tens;
    logic [3:0]          w_val_ones;
    logic [3:0]          w_digit;
    logic                w_blank;
    logic [6:0]          w_seg;
    logic [3:0]          w_an;

    assign w_s_sync = r_sync[SYNC_STAGES-1];
    // Only take a sample that agrees with the previous one, so bits that
    // cross the domain on different edges never produce a bogus value.
    assign w_accept = (w_s_sync == r_s_prev);
    assign w_wrap   = w_accept && (r_value_q == 4'd15) && (w_s_sync == 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= 4'd0;
            end
            r_s_prev  <= 4'd0;
            r_value_q <= 4'd0;
        end else begin
            r_sync[0] <= counter_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_s_prev <= w_s_sync;
            if (w_accept) begin
                r_value_q <= w_s_sync;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrap_ones  <= 4'd0;
            r_wrap_tens  <= 4'd0;
            r_wrap_pulse <= 1'b0;
        end else begin
            r_wrap_pulse <= w_wrap;
            if (w_wrap) begin
                if (r_wrap_ones == 4'd9) begin
                    r_wrap_ones <= 4'd0;
                    r_wrap_tens <= (r_wrap_tens == 4'd9) ? 4'd0 : r_wrap_tens + 4'd1;
                end else begin
                    r_wrap_ones <= r_wrap_ones + 4'd1;
                end
            end
        end
    end

    assign w_scan_tc = (r_scan == c_SCAN_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan <= '0;
            r_idx  <= c_DIG_0;
        end else if (w_scan_tc) begin
            r_scan <= '0;
            r_idx  <= r_idx + 2'd1;
        end else begin
            r_scan <= r_scan + c_SCAN_ONE;
        end
    end

    assign w_val_tens = (r_value_q >= 4'd10);
    assign w_val_ones = w_val_tens ? (r_value_q - 4'd10) : r_value_q;

    always_comb begin
        w_digit = w_val_ones;
        w_blank = 1'b0;
        case (r_idx)
            c_DIG_0: begin
                w_digit = w_val_ones;
                w_blank = 1'b0;
            end
            c_DIG_1: begin
                w_digit = {3'b000, w_val_tens};
                w_blank = !w_val_tens;
            end
            c_DIG_2: begin
                w_digit = r_wrap_ones;
                w_blank = 1'b0;
            end
            default: begin
                w_digit = r_wrap_tens;
                w_blank = (r_wrap_tens == 4'd0);
            end
        endcase
    end

    bcd_to_seg7 u_bcd_to_seg7 (
        .i_digit (w_digit),
        .i_blank (w_blank),
        .o_seg   (w_seg)
    );

    assign w_an = ~(4'b0001 << r_idx);

    // Registered pins: one cycle behind the index, glitch-free at the board.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an  <= c_AN_OFF;
            r_seg <= c_SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an;
            r_seg <= w_seg;
            r_dp  <= (r_idx != c_DIG_2);
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign wrap_pulse = r_wrap_pulse;

endmodule

`default_nettype wire

// File: tb/tb_count_display_ctrl.sv
// ============================================================================
// Module      : tb_count_display_ctrl
// Description : Randomised scoreboard bench for count_display_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_count_display_ctrl;

    localparam int c_REFRESH_DIV = 4;
    localparam int c_SYNC_STAGES = 2;
    localparam int c_LATENCY     = c_SYNC_STAGES + 2;

    typedef logic [3:0][6:0] frame_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] counter_in = 4'd0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       wrap_pulse;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    bit         obs = 1'b0;
    bit         run_chk = 1'b0;

    frame_t     frame_q[$];
    int         wrap_q[$];

    int         m_prev = 0;
    int         m_wraps = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};
    localparam logic [6:0] c_BLANK = 7'b1111111;

    count_display_ctrl #(
        .REFRESH_DIV (c_REFRESH_DIV),
        .SYNC_STAGES (c_SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .counter_in (counter_in),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .wrap_pulse (wrap_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic frame_t make_frame(input int v, input int w);
        frame_t f;
        f[0] = seg_tab[v % 10];
        f[1] = (v >= 10) ? seg_tab[1] : c_BLANK;
        f[2] = seg_tab[w % 10];
        f[3] = (w >= 10) ? seg_tab[w / 10] : c_BLANK;
        return f;
    endfunction

    // Monitor: checks scan shape, displayed frame and wrap pulses.
    initial begin
        frame_t cur;
        bit     prev_obs;
        int     idx;
        int     exp_cyc;
        cur = '1;
        prev_obs = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (run_chk) begin
                chk("an_one_hot", $countones(~an), 1);
            end
            if (obs) begin
                if (!prev_obs) begin
                    if (frame_q.size() == 0) begin
                        chk("frame_queue_empty", 0, 1);
                    end else begin
                        cur = frame_q.pop_front();
                    end
                end
                idx = (an == 4'b1110) ? 0 : (an == 4'b1101) ? 1 : (an == 4'b1011) ? 2 : 3;
                chk($sformatf("seg_digit%0d", idx), seg, cur[idx]);
                chk($sformatf("dp_digit%0d", idx), dp, (idx == 2) ? 1'b0 : 1'b1);
            end
            prev_obs = obs;
            if (wrap_pulse) begin
                if (wrap_q.size() == 0) begin
                    chk("unexpected_wrap_pulse", 1, 0);
                end else begin
                    exp_cyc = wrap_q.pop_front();
                    chk("wrap_pulse_cycle", cyc, exp_cyc);
                end
            end
        end
    end

    // Present a settled value, then expose the display for a window of n cycles.
    task automatic hold(input int v, input int n, input bit glitch);
        if (v == 0 && m_prev == 15) begin
            m_wraps = (m_wraps + 1) % 100;
            wrap_q.push_back(cyc + c_LATENCY);
        end
        counter_in = 4'(v);
        m_prev = v;
        repeat (c_LATENCY + 2) @(negedge clk);
        frame_q.push_back(make_frame(v, m_wraps));
        obs = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (glitch && k == n / 2) begin
                counter_in = ~counter_in;
                @(negedge clk);
                counter_in = 4'(v);
            end
        end
        obs = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        obs = 1'b0;
        run_chk = 1'b0;
        reset = 1'b1;
        counter_in = 4'd0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #2;
            chk("reset_an", an, 4'b1111);
            chk("reset_seg", seg, 7'b1111111);
            chk("reset_dp", dp, 1'b1);
            chk("reset_wrap_pulse", wrap_pulse, 1'b0);
        end
        @(negedge clk);
        reset = 1'b0;
        m_prev = 0;
        m_wraps = 0;
        wrap_q.delete();
        @(posedge clk);
        #2;
        chk("first_step_an", an, 4'b1110);
        chk("first_step_seg", seg, seg_tab[0]);
        run_chk = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        hold(0, 16, 1'b0);
        hold(12, 16, 1'b0);
        hold(15, 16, 1'b0);
        hold(0, 16, 1'b0);
        hold(7, 16, 1'b0);
        hold(0, 16, 1'b0);
        hold(5, 20, 1'b1);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                hold(15, 16 + $urandom_range(0, 6), 1'b0);
                hold(0, 16 + $urandom_range(0, 6), 1'b0);
            end else begin
                hold($urandom_range(0, 15), 16 + $urandom_range(0, 6), 1'b0);
            end
        end
        for (int i = 0; i < 100; i++) begin
            hold(15, 16 + $urandom_range(0, 4), 1'b0);
            hold(0, 16 + $urandom_range(0, 4), 1'b0);
        end
        hold(9, 16, 1'b0);
        repeat (2) @(negedge clk);
        do_reset();
        hold(15, 16, 1'b0);
        hold(0, 16, 1'b0);
        repeat (4) @(negedge clk);
        chk("wrap_pulses_outstanding", wrap_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
